// File: rtl/sd_presence.sv
// SD card-detect debouncer with power-up hold and SPI gating.
// The card pins stay idle until the inserted card is debounced and powered.
module sd_presence #(
  parameter int TICK_DIV       = 28000,
  parameter int DEBOUNCE_TICKS = 10,
  parameter int POWERUP_TICKS  = 50
) (
  input  logic clk28,
  input  logic rst,
  input  logic sd_cd_n,
  input  logic spi_cs_in,
  input  logic spi_sck_in,
  input  logic spi_mosi_in,
  input  logic changed_clr,
  output logic sd_cs,
  output logic sd_sck,
  output logic sd_mosi,
  output logic card_present,
  output logic card_ready,
  output logic card_changed
);

  localparam logic [2:0] ABSENT   = 3'd0;
  localparam logic [2:0] INS_WAIT = 3'd1;
  localparam logic [2:0] POWERUP  = 3'd2;
  localparam logic [2:0] READY    = 3'd3;
  localparam logic [2:0] REM_WAIT = 3'd4;

  logic [2:0]  state;
  logic [2:0]  nxt;
  logic        s1;
  logic        s2;
  logic        cd;
  logic [15:0] pre;
  logic [7:0]  cnt;
  logic [7:0]  target;
  logic        tick;
  logic        done;
  logic        set_chg;

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sd_cd_n;
      s2 <= s1;
    end
  end

  assign cd   = ~s2;
  assign tick = (pre == 16'(TICK_DIV - 1));

  always_comb begin
    target = 8'd0;
    case (state)
      INS_WAIT: target = 8'(DEBOUNCE_TICKS);
      REM_WAIT: target = 8'(DEBOUNCE_TICKS);
      POWERUP:  target = 8'(POWERUP_TICKS);
      default:  target = 8'd0;
    endcase
  end

  assign done = tick && (target != 8'd0) && (cnt == target - 8'd1);

  always_comb begin
    nxt = state;
    case (state)
      ABSENT:   if (cd) nxt = INS_WAIT;
      INS_WAIT: if (!cd) nxt = ABSENT;
                else if (done) nxt = POWERUP;
      POWERUP:  if (!cd) nxt = ABSENT;
                else if (done) nxt = READY;
      READY:    if (!cd) nxt = REM_WAIT;
      REM_WAIT: if (cd) nxt = READY;
                else if (done) nxt = ABSENT;
      default:  nxt = ABSENT;
    endcase
  end

  // Every state change restarts the window so it spans exactly N ticks.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      state <= ABSENT;
      pre   <= 16'd0;
      cnt   <= 8'd0;
    end else begin
      state <= nxt;
      if (nxt != state) begin
        pre <= 16'd0;
        cnt <= 8'd0;
      end else begin
        pre <= tick ? 16'd0 : pre + 16'd1;
        if (tick && cnt != target)
          cnt <= cnt + 8'd1;
      end
    end
  end

  assign set_chg = (state == POWERUP && nxt == READY)
                || (nxt == ABSENT
                    && (state == REM_WAIT || state == POWERUP));

  always_ff @(posedge clk28 or posedge rst) begin
    if (rst)
      card_changed <= 1'b0;
    else if (set_chg)
      card_changed <= 1'b1;
    else if (changed_clr)
      card_changed <= 1'b0;
  end

  assign card_present = (state == POWERUP)
                     || (state == READY)
                     || (state == REM_WAIT);
  assign card_ready   = (state == READY) || (state == REM_WAIT);

  assign sd_cs   = card_ready ? spi_cs_in   : 1'b1;
  assign sd_sck  = card_ready ? spi_sck_in  : 1'b0;
  assign sd_mosi = card_ready ? spi_mosi_in : 1'b1;

endmodule

// File: tb/tb_sd_presence.sv
// Bench for sd_presence: directed scenarios plus random card-detect runs
// checked against a time-in-state reference model.
module tb_sd_presence;

  localparam int TD = 4;
  localparam int DB = 3;
  localparam int PU = 2;

  logic clk28 = 1'b0;
  logic rst = 1'b0;
  logic sd_cd_n = 1'b1;
  logic spi_cs_in = 1'b1;
  logic spi_sck_in = 1'b0;
  logic spi_mosi_in = 1'b1;
  logic changed_clr = 1'b0;
  logic sd_cs, sd_sck, sd_mosi;
  logic card_present, card_ready, card_changed;

  int vectors = 0;
  int errs = 0;

  sd_presence #(
    .TICK_DIV(TD),
    .DEBOUNCE_TICKS(DB),
    .POWERUP_TICKS(PU)
  ) dut (
    .clk28(clk28),
    .rst(rst),
    .sd_cd_n(sd_cd_n),
    .spi_cs_in(spi_cs_in),
    .spi_sck_in(spi_sck_in),
    .spi_mosi_in(spi_mosi_in),
    .changed_clr(changed_clr),
    .sd_cs(sd_cs),
    .sd_sck(sd_sck),
    .sd_mosi(sd_mosi),
    .card_present(card_present),
    .card_ready(card_ready),
    .card_changed(card_changed)
  );

  always #5 clk28 = ~clk28;

  typedef enum {M_ABS, M_INS, M_PU, M_RDY, M_REM} mst_t;
  mst_t m_st;
  bit   m_q[2];
  int   m_age;
  bit   m_chg;

  task automatic chk(string tag, logic [7:0] obs, logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_st = M_ABS;
    m_q[0] = 1'b0;
    m_q[1] = 1'b0;
    m_age = 0;
    m_chg = 1'b0;
  endtask

  task automatic check_all(string tag);
    bit pres, rdy;
    pres = (m_st == M_PU) || (m_st == M_RDY) || (m_st == M_REM);
    rdy  = (m_st == M_RDY) || (m_st == M_REM);
    chk({tag, ".present"}, 8'(card_present), 8'(pres));
    chk({tag, ".ready"}, 8'(card_ready), 8'(rdy));
    chk({tag, ".changed"}, 8'(card_changed), 8'(m_chg));
    chk({tag, ".spi"}, {5'd0, sd_cs, sd_sck, sd_mosi},
        rdy ? {5'd0, spi_cs_in, spi_sck_in, spi_mosi_in}
            : 8'b0000_0101);
  endtask

  // One clock: model consumes pre-edge inputs, outputs checked at negedge.
  task automatic cyc(string tag);
    bit cd, win;
    mst_t nst;
    cd  = !m_q[1];
    nst = m_st;
    case (m_st)
      M_ABS: if (cd) nst = M_INS;
      M_INS: if (!cd) nst = M_ABS;
             else if (m_age + 1 == DB * TD) nst = M_PU;
      M_PU:  if (!cd) nst = M_ABS;
             else if (m_age + 1 == PU * TD) nst = M_RDY;
      M_RDY: if (!cd) nst = M_REM;
      M_REM: if (cd) nst = M_RDY;
             else if (m_age + 1 == DB * TD) nst = M_ABS;
      default: nst = M_ABS;
    endcase
    win = (m_st == M_PU && nst == M_RDY)
       || (nst == M_ABS && (m_st == M_PU || m_st == M_REM));
    @(posedge clk28);
    if (rst) begin
      model_reset();
    end else begin
      if (win) m_chg = 1'b1;
      else if (changed_clr) m_chg = 1'b0;
      m_age = (nst != m_st) ? 0 : m_age + 1;
      m_st = nst;
      m_q[1] = m_q[0];
      m_q[0] = sd_cd_n;
    end
    @(negedge clk28);
    check_all(tag);
  endtask

  task automatic do_reset(int n);
    rst = 1'b1;
    model_reset();
    #1;
    check_all("rst_async");
    repeat (n) cyc("rst_hold");
    rst = 1'b0;
  endtask

  task automatic wait_ready(int bound, output int n);
    n = 0;
    while (!card_ready && n < bound) begin
      cyc("wait");
      n++;
    end
    if (!card_ready) begin
      vectors++;
      errs++;
      $error("FAIL wait_ready timeout got %0d expected <%0d", n, bound);
    end
  endtask

  initial begin
    int n;
    int run;
    model_reset();
    @(negedge clk28);
    do_reset(2);
    chk("reset.cs", 8'(sd_cs), 8'd1);
    chk("reset.mosi", 8'(sd_mosi), 8'd1);
    repeat (4) cyc("idle");

    // Insertion timing and clear race on the POWERUP->READY edge.
    sd_cd_n = 1'b0;
    repeat (22) cyc("insert");
    chk("insert.not_ready_22", 8'(card_ready), 8'd0);
    chk("insert.present_22", 8'(card_present), 8'd1);
    changed_clr = 1'b1;
    cyc("race");
    changed_clr = 1'b0;
    chk("race.ready_23", 8'(card_ready), 8'd1);
    chk("race.changed_set_wins", 8'(card_changed), 8'd1);
    spi_cs_in = 1'b0; spi_sck_in = 1'b1; spi_mosi_in = 1'b0;
    cyc("pass");
    changed_clr = 1'b1;
    cyc("clr");
    changed_clr = 1'b0;
    chk("clr.changed", 8'(card_changed), 8'd0);

    // Short removal glitch is absorbed.
    sd_cd_n = 1'b1;
    repeat (5) cyc("glitch");
    sd_cd_n = 1'b0;
    repeat (20) begin
      spi_sck_in = ~spi_sck_in;
      cyc("glitch_after");
    end
    chk("glitch.ready", 8'(card_ready), 8'd1);
    chk("glitch.changed", 8'(card_changed), 8'd0);

    // Full removal with the SPI clock toggling.
    sd_cd_n = 1'b1;
    repeat (30) begin
      spi_sck_in = ~spi_sck_in;
      cyc("remove");
    end
    chk("remove.present", 8'(card_present), 8'd0);
    chk("remove.changed", 8'(card_changed), 8'd1);
    chk("remove.sck", 8'(sd_sck), 8'd0);

    // Bounce shorter than the debounce window.
    do_reset(1);
    sd_cd_n = 1'b0;
    repeat (10) cyc("bounce_low");
    sd_cd_n = 1'b1;
    repeat (30) cyc("bounce_high");
    chk("bounce.changed", 8'(card_changed), 8'd0);

    // Reset while powering up restarts the whole sequence.
    sd_cd_n = 1'b0;
    repeat (17) cyc("pu_enter");
    chk("pu.present", 8'(card_present), 8'd1);
    do_reset(2);
    wait_ready(60, n);
    chk("pu.restart_cycles", 8'(n), 8'd21);

    // Random card-detect runs, SPI traffic, clears and resets.
    run = 0;
    repeat (2000) begin
      if (run == 0) begin
        sd_cd_n = 1'($urandom_range(0, 1));
        run = ($urandom_range(0, 3) == 0) ? $urandom_range(30, 60)
                                          : $urandom_range(1, 16);
      end
      run--;
      spi_cs_in   = 1'($urandom);
      spi_sck_in  = 1'($urandom);
      spi_mosi_in = 1'($urandom);
      changed_clr = ($urandom_range(0, 15) == 0);
      if ($urandom_range(0, 399) == 0) begin
        changed_clr = 1'b0;
        do_reset($urandom_range(1, 3));
      end else begin
        cyc("rand");
      end
    end
    changed_clr = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
